// File: rtl/ieee_adder_sequencer.sv
// Request/response sequencer around an external IEEE-754 single-precision adder.
// One operation in flight: register operands, wait the adder latency, capture and classify.
module ieee_adder_sequencer #(
    parameter int ADD_LATENCY = 0,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic             in_op,
    output logic [31:0]      number1,
    output logic [31:0]      number2,
    output logic             op,
    input  logic [31:0]      result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [3:0]       out_flags,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam int LW = (ADD_LATENCY > 0) ? $clog2(ADD_LATENCY + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } state_t;

    state_t          state;
    logic [LW-1:0]   lat_cnt;

    // Flag order is {nan, inf, zero, denorm}; at most one bit can be set.
    function automatic logic [3:0] classify(input logic [31:0] r);
        logic [7:0]  ex;
        logic [22:0] man;
        ex  = r[30:23];
        man = r[22:0];
        return {(ex == 8'hFF) && (man != '0),
                (ex == 8'hFF) && (man == '0),
                (ex == 8'h00) && (man == '0),
                (ex == 8'h00) && (man != '0)};
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            number1    <= '0;
            number2    <= '0;
            op         <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
            busy       <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        number1 <= in_a;
                        number2 <= in_b;
                        op      <= in_op;
                        lat_cnt <= LW'(ADD_LATENCY);
                        busy    <= 1'b1;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        out_result <= result;
                        out_flags  <= classify(result);
                        out_valid  <= 1'b1;
                        state      <= HOLD;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                HOLD: begin
                    // Returning to IDLE here keeps a new accept out of the handshake cycle.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        op_count  <= op_count + 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready = rst_n && (state == IDLE);

endmodule

// File: doc/ieee_adder_sequencer.md
Name: ieee_adder_sequencer

Overview:
- Transaction front-end/back-end wrapped around IEEE_adder.
- Accepts one operand pair plus op via a valid/ready request.
- Drives the adder's number1/number2/op inputs from registers and waits a fixed adder latency.
- Captures the adder's result, classifies it, and presents it downstream on a valid/ready response channel; one operation in flight at a time.

Parameters:
ADD_LATENCY, 0, clock edges between operands appearing on number1/number2/op and result being valid (0 = combinational adder)
CNT_W, 16, width of the completed-operation counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  sequencer can accept a request
in_a  in  32  IEEE-754 single operand A
in_b  in  32  IEEE-754 single operand B
in_op  in  1  0 = A+B, 1 = A-B
number1  out  32  to adder operand 1 (registered)
number2  out  32  to adder operand 2 (registered)
op  out  1  to adder op (registered)
result  in  32  from adder result
out_valid  out  1  response valid
out_ready  in  1  downstream accepts response
out_result  out  32  captured adder result
out_flags  out  4  {nan, inf, zero, denorm} of out_result
busy  out  1  high whenever state != IDLE
op_count  out  CNT_W  completed responses, wraps

Behaviour:
- Reset (rst_n low at a rising edge): state IDLE; number1, number2, out_result, out_flags, op_count cleared to 0; op, out_valid, busy cleared to 0. in_ready reads 0 while rst_n is low, 1 in IDLE afterwards.
- FSM states: IDLE, WAIT, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: register in_a->number1, in_b->number2, in_op->op; load lat_cnt=ADD_LATENCY; go to WAIT.
- WAIT:
  - in_ready=0.
  - If lat_cnt==0: capture result into out_result, compute out_flags from the same value, go to HOLD.
  - Otherwise decrement lat_cnt.
  - The capture edge is therefore ADD_LATENCY+1 edges after the accept edge.
- HOLD:
  - out_valid=1, in_ready=0.
  - On out_ready: op_count<=op_count+1 (wraps to 0 at 2^CNT_W-1), out_valid deasserts next cycle, go to IDLE.
  - out_result and out_flags stay stable until the handshake.
- Latency: out_valid rises ADD_LATENCY+2 cycles after the cycle in which the request is accepted. Minimum request-to-request spacing is ADD_LATENCY+3 cycles with out_ready held high. No accept in the same cycle as a response handshake.
- number1, number2 and op hold their last value in IDLE and HOLD; they change only on accept.
- Flags (exp=r[30:23], man=r[22:0]):
  - nan = exp==8'hFF && man!=0
  - inf = exp==8'hFF && man==0
  - zero = exp==0 && man==0 (either sign)
  - denorm = exp==0 && man!=0
  - Exactly one flag or none is set.
- in_valid while not IDLE: ignored, no effect on state. in_a, in_b and in_op only sampled at accept.
- Reset mid-operation (WAIT or HOLD): the operation is discarded, no out_valid is produced, and op_count is cleared.

Test Plan:
- Accept in_a=0x40ADF06F, in_b=0x40ADEAB3, in_op=1 with ADD_LATENCY=0; bench adder model returns 0x3A378000. Required response: out_valid 2 cycles after accept, out_result=0x3A378000, out_flags=0000, op_count=1.
- With ADD_LATENCY=3: 0x3F800000+0x3F800000, op=0 -> out_result=0x40000000 exactly 5 cycles after accept. number1 and number2 hold 0x3F800000 throughout WAIT.
- Classification checks:
  - 0x40400000-0x40400000 -> 0x00000000, flags zero=1.
  - 0x80000000 result -> zero=1.
  - 0x7F800000 -> inf=1.
  - 0x7FC00000 -> nan=1.
  - 0x00000001 -> denorm=1.
- Backpressure: out_ready low for 5 cycles in HOLD -> out_valid stays 1, out_result unchanged, in_ready 0, and a second in_valid is not accepted. On out_ready: IDLE next cycle, then the pending request is accepted.
- Reset mid-op: drop rst_n for 1 cycle while in WAIT -> next cycle state IDLE, out_valid=0, number1=0, op_count=0, and no response ever appears.
- CNT_W=4: 16 back-to-back operations with out_ready=1 -> op_count reads 15 after the 15th handshake, 0 after the 16th. Spacing is ADD_LATENCY+3 cycles per operation.
